// File: rtl/pulse_event_arbiter.sv
// ---------------------------------------------------------------------------
// pulse_event_arbiter
//
// Purpose:
//   Watches N single-bit inputs for one-cycle 0-1-0 pulses and keeps a
//   saturating count of pending events per channel. A round-robin arbiter
//   drains the pending events onto a single valid/ready port, one channel id
//   per transfer. Intended to sit between per-signal pulse detection and one
//   downstream event consumer such as an interrupt or logging unit.
//
// Ports:
//   clk        in   1     clock, all state updates on the rising edge
//   rst        in   1     asynchronous, active-low reset
//   a          in   N     monitored inputs, one per channel
//   out_valid  out  1     an event is being offered downstream
//   out_ready  in   1     downstream accepts; transfer = out_valid & out_ready
//   out_id     out  ID_W  channel index of the offered event
//   pend_any   out  1     at least one channel has a pending event
//   ovf        out  N     sticky per-channel overflow flags
//   clr_ovf    in   1     one-cycle strobe clearing all ovf bits
//
// Parameters:
//   N      number of channels (N >= 2)
//   CNT_W  width of each pending counter, saturating at 2**CNT_W-1
//
// Build option:
//   PULSE_ARB_EDGE_EN  when defined, any rising edge of a[i] counts as an
//                      event (any pulse width) instead of the strict one-cycle
//                      0-1-0 pulse; the second history stage is then omitted.
// ---------------------------------------------------------------------------

module pulse_event_arbiter #(
  parameter int N     = 4,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         a,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_id,
  output logic                 pend_any,
  output logic [N-1:0]         ovf,
  input  logic                 clr_ovf
);

  localparam int ID_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  state_t state;
  state_t next_state;

  logic [N-1:0]            a_r;
  logic [N-1:0]            det;
  logic [N-1:0][CNT_W-1:0] cnt;
  logic [N-1:0][CNT_W-1:0] cnt_next;
  logic [N-1:0]            ovf_set;
  logic [N-1:0]            nonzero;
  logic [N-1:0]            accept;
  logic [ID_W-1:0]         last_grant;
  logic [ID_W-1:0]         pick_id;
  logic                    pick_found;
  logic                    transfer;

`ifdef PULSE_ARB_EDGE_EN
  // Edge mode: one history stage is enough to see a 0->1 transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r <= '0;
    end else begin
      a_r <= a;
    end
  end

  assign det = ~a_r & a;
`else
  logic [N-1:0] a_rr;

  // Two history stages; the current input is the third sample of the 0-1-0
  // window, so the event is flagged in the cycle the input falls. History
  // resets to 0 so a level that is high right after reset still qualifies.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r  <= '0;
      a_rr <= '0;
    end else begin
      a_r  <= a;
      a_rr <= a_r;
    end
  end

  assign det = ~a_rr & a_r & ~a;
`endif

  assign transfer = out_valid & out_ready;

  // Accept strobe for the channel currently being offered.
  always_comb begin
    accept = '0;
    for (int i = 0; i < N; i++) begin
      accept[i] = transfer && (out_id == ID_W'(i));
    end
  end

  // Per-channel counter update. A detection and an accept in the same cycle
  // cancel out. A detection that would overflow leaves the count at max and
  // raises the overflow flag instead. An accept never sees a zero count
  // because a channel is only offered once its count is nonzero and nothing
  // else decrements it while offered.
  always_comb begin
    cnt_next = cnt;
    ovf_set  = '0;
    for (int i = 0; i < N; i++) begin
      if (det[i] && !accept[i]) begin
        if (cnt[i] == CNT_MAX) begin
          ovf_set[i] = 1'b1;
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end else if (accept[i] && !det[i]) begin
        cnt_next[i] = cnt[i] - 1'b1;
      end
    end
  end

  // Counter and overflow registers. A new overflow beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      ovf <= '0;
    end else begin
      cnt <= cnt_next;
      ovf <= (ovf & ~{N{clr_ovf}}) | ovf_set;
    end
  end

  // Pending flags come straight from the registered counters.
  always_comb begin
    nonzero = '0;
    for (int i = 0; i < N; i++) begin
      nonzero[i] = |cnt[i];
    end
  end

  assign pend_any = |nonzero;

  // Round-robin pick: scan from the channel after the last grant, wrapping
  // around, and take the first one with a pending event. The last granted
  // channel is scanned last, which bounds any channel's wait to N transfers.
  always_comb begin
    int s;
    logic [ID_W-1:0] cand;
    s          = 0;
    cand       = '0;
    pick_found = 1'b0;
    pick_id    = '0;
    for (int off = 1; off <= N; off++) begin
      s = int'(last_grant) + off;
      if (s >= N) begin
        s = s - N;
      end
      cand = ID_W'(s);
      if (!pick_found && nonzero[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic: one arbitration cycle in IDLE, then hold the offer
  // until the consumer takes it.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pick_found) next_state = OFFER;
      OFFER:   if (out_ready)  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    out_valid = (state == OFFER);
  end

  // The chosen id is latched in IDLE so it cannot change while offered; the
  // grant pointer moves only on an actual transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_id     <= '0;
      last_grant <= ID_W'(N - 1);
    end else begin
      if (state == IDLE && pick_found) begin
        out_id <= pick_id;
      end
      if (transfer) begin
        last_grant <= out_id;
      end
    end
  end

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pulse_event_arbiter
//
// Directed bench for pulse_event_arbiter (N=4, CNT_W=3). Stimulus pushes the
// hand-computed channel ids it expects into a queue; a monitor pops and
// compares on every accepted transfer and also checks that an offer stays
// stable while out_ready is low. The main thread checks timing, pend_any and
// ovf at specific cycles.
// ---------------------------------------------------------------------------

module tb_pulse_event_arbiter;

`ifdef PULSE_ARB_EDGE_EN
  localparam int SH = 1;
`else
  localparam int SH = 0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_id;
  logic       pend_any;
  logic [3:0] ovf;
  logic       clr_ovf;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_q[$];

  pulse_event_arbiter #(.N(4), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .pend_any  (pend_any),
    .ovf       (ovf),
    .clr_ovf   (clr_ovf)
  );

  // 10 time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation still running at %0t, limit 100000", $time);
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle high pulse on the masked channels, followed by one low cycle.
  // Returns just after the edge that registers the resulting count.
  task automatic applyStimulus(input logic [3:0] mask);
    a = mask;
    tick();
    a = 4'b0000;
    tick();
  endtask

  task automatic resetDut();
    rst     = 1'b0;
    a       = 4'b0000;
    clr_ovf = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  // Scoreboard monitor and offer-stability check.
  initial begin
    bit pv;
    bit pr;
    int pid;
    int e;
    pv  = 1'b0;
    pr  = 1'b0;
    pid = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          checkOutput("hold_valid", out_valid, 1);
          checkOutput("hold_id", out_id, pid);
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL sb_unexpected: got event id %0d, expected no event at %0t", out_id, $time);
          end else begin
            e = exp_q.pop_front();
            checkOutput("sb_id", out_id, e);
          end
        end
        pv  = out_valid;
        pr  = out_ready;
        pid = out_id;
      end
    end
  end

  initial begin
    int  s;
    bit  ev;
    bit  got;
    rst       = 1'b1;
    a         = 4'b0000;
    out_ready = 1'b0;
    clr_ovf   = 1'b0;
    #2 rst = 1'b0;

    // Reset state while held in reset.
    #10;
    checkOutput("rst_valid", out_valid, 0);
    checkOutput("rst_id", out_id, 0);
    checkOutput("rst_pend", pend_any, 0);
    checkOutput("rst_ovf", ovf, 0);
    tick();
    rst = 1'b1;
    tick();

    // Single pulse on channel 2 with the consumer always ready.
    $display("[TB] single pulse on a[2]");
    out_ready = 1'b1;
    exp_q.push_back(2);
    applyStimulus(4'b0100);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      s  = k + SH;
      ev = (s == 1);
      checkOutput("t2_valid", out_valid, ev);
      if (ev) checkOutput("t2_id", out_id, 2);
      checkOutput("t2_pend", pend_any, (s <= 1));
    end

    // Channel 1 held high for three cycles.
    $display("[TB] wide pulse on a[1]");
    tick();
    a = 4'b0010;
    repeat (3) tick();
    a = 4'b0000;
`ifdef PULSE_ARB_EDGE_EN
    exp_q.push_back(1);
`endif
    repeat (8) tick();
    @(negedge clk);
    checkOutput("t3_pend", pend_any, 0);
    checkOutput("t3_valid", out_valid, 0);
    checkOutput("t3_queue", exp_q.size(), 0);

    // Simultaneous pulses on all channels right after reset.
    $display("[TB] simultaneous pulses");
    resetDut();
    out_ready = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    applyStimulus(4'b1111);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      s  = k + SH;
      ev = (s % 2 == 1) && (s <= 7);
      checkOutput("t4_valid", out_valid, ev);
      if (ev) checkOutput("t4_id", out_id, (s - 1) / 2);
    end
    checkOutput("t4_pend", pend_any, 0);

    // Back-pressure: the offer must stay put until out_ready rises.
    $display("[TB] back-pressure on id 0");
    resetDut();
    out_ready = 1'b0;
    exp_q.push_back(0);
    applyStimulus(4'b0001);
    got = 1'b0;
    for (int w = 0; w < 6 && !got; w++) begin
      @(negedge clk);
      got = out_valid;
    end
    checkOutput("t5_offer", got, 1);
    repeat (10) begin
      @(negedge clk);
      checkOutput("t5_hold_valid", out_valid, 1);
      checkOutput("t5_hold_id", out_id, 0);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("t5_accept_valid", out_valid, 1);
    @(negedge clk);
    checkOutput("t5_after_valid", out_valid, 0);
    checkOutput("t5_after_pend", pend_any, 0);

    // Saturation, overflow and clear priority on channel 0.
    $display("[TB] saturation on a[0]");
    resetDut();
    out_ready = 1'b0;
    for (int p = 1; p <= 8; p++) begin
      applyStimulus(4'b0001);
      if (p == 7) begin
        @(negedge clk);
        checkOutput("t6_ovf_at7", ovf, 0);
      end
    end
    @(negedge clk);
    checkOutput("t6_ovf_at8", ovf, 1);
    a       = 4'b0001;
    clr_ovf = (SH == 1);
    tick();
    a       = 4'b0000;
    clr_ovf = (SH == 0);
    tick();
    clr_ovf = 1'b0;
    @(negedge clk);
    checkOutput("t6_ovf_set_wins", ovf, 1);
    tick();
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    @(negedge clk);
    checkOutput("t6_ovf_cleared", ovf, 0);
    checkOutput("t6_pend", pend_any, 1);
    repeat (7) exp_q.push_back(0);
    tick();
    out_ready = 1'b1;
    for (int w = 0; w < 40 && exp_q.size() != 0; w++) begin
      @(negedge clk);
    end
    checkOutput("t6_drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    checkOutput("t6_drain_pend", pend_any, 0);
    checkOutput("t6_drain_valid", out_valid, 0);

    // Asynchronous reset in the middle of an offer.
    $display("[TB] reset during offer");
    resetDut();
    out_ready = 1'b0;
    repeat (8) applyStimulus(4'b1000);
    @(negedge clk);
    checkOutput("t7_pre_valid", out_valid, 1);
    checkOutput("t7_pre_id", out_id, 3);
    checkOutput("t7_pre_ovf", ovf, 8);
    #2 rst = 1'b0;
    #1;
    checkOutput("t7_rst_valid", out_valid, 0);
    checkOutput("t7_rst_ovf", ovf, 0);
    checkOutput("t7_rst_pend", pend_any, 0);
    checkOutput("t7_rst_id", out_id, 0);
    tick();
    tick();
    rst       = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("t7_post_valid", out_valid, 0);
    checkOutput("t7_post_pend", pend_any, 0);

    checkOutput("final_queue", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
